// File: rtl/fifo_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_pkg : shared state encoding and default widths for the FIFO drainer
// Revision : 1.0
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int c_DATA_BITS_DEF = 10;
  localparam int c_CNT_BITS_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ERR   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/skid_buf2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// skid_buf2 : two-entry in-order output buffer with synchronous clear
// Revision  : 1.0
// ---------------------------------------------------------------------------
module skid_buf2 #(
  parameter int DATA_BITS = fifo_pkg::c_DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clear,
  input  logic                 i_push,
  input  logic                 i_pop,
  input  logic [DATA_BITS-1:0] i_data,
  output logic [DATA_BITS-1:0] o_data,
  output logic [1:0]           o_count
);

  logic [DATA_BITS-1:0] r_mem [2];
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [1:0]           r_count;
  logic                 w_pop;
  logic                 w_push;

  assign w_pop   = i_pop && (r_count != 2'd0);
  assign w_push  = i_push && ((r_count != 2'd2) || w_pop);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_clear) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_drain.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_drain : watermark/flush driven FIFO drainer with valid/ready output
// Revision   : 1.0
// ---------------------------------------------------------------------------
module fifo_drain
  import fifo_pkg::*;
#(
  parameter int DATA_BITS = c_DATA_BITS_DEF,
  parameter int CNT_BITS  = c_CNT_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] fifo_data_out,
  input  logic                 fifo_empty_out,
  input  logic                 fifo_almost_full,
  input  logic                 fifo_almost_empty,
  input  logic                 error_fifo_out,
  input  logic                 flush,
  output logic                 fifo_read,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic [CNT_BITS-1:0]  word_count,
  output logic                 error_out,
  output logic                 busy
);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_inflight;
  logic [CNT_BITS-1:0] r_word_count;
  logic [1:0]          w_buf_count;
  logic                w_in_err;
  logic                w_pop;
  logic                w_push;
  logic                w_space_ok;
  logic                w_read;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (fifo_almost_full || flush) w_state_next = ST_DRAIN;
      ST_DRAIN: if (flush ? fifo_empty_out : fifo_almost_empty) w_state_next = ST_IDLE;
      ST_ERR:   w_state_next = ST_ERR;
      default:  w_state_next = ST_IDLE;
    endcase
    if (error_fifo_out) begin
      w_state_next = ST_ERR;
    end
  end

  assign w_in_err  = (r_state == ST_ERR);
  assign valid_out = (w_buf_count != 2'd0) && !w_in_err;
  assign w_pop     = valid_out && ready_in;
  assign w_push    = r_inflight && !w_in_err;

  // Crediting a same-cycle pop keeps one word per cycle in steady state;
  // a read is also withheld in the cycle the FSM is about to leave DRAIN.
  assign w_space_ok = (({1'b0, w_buf_count} + {2'b00, r_inflight}) - {2'b00, w_pop}) < 3'd2;
  assign w_read     = (r_state == ST_DRAIN) && (w_state_next == ST_DRAIN) &&
                      !fifo_empty_out && w_space_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inflight   <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_inflight <= w_read;
      if (w_pop) begin
        r_word_count <= r_word_count + CNT_BITS'(1);
      end
    end
  end

  skid_buf2 #(
    .DATA_BITS (DATA_BITS)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_in_err),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (fifo_data_out),
    .o_data  (data_out),
    .o_count (w_buf_count)
  );

  assign fifo_read  = w_read;
  assign word_count = r_word_count;
  assign error_out  = w_in_err;
  assign busy       = (r_state == ST_DRAIN);

endmodule
`default_nettype wire

// File: tb/tb_fifo_drain.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fifo_drain : vector table plus FIFO model / scoreboard bench
// Revision      : 1.0
// ---------------------------------------------------------------------------
module tb_fifo_drain;

  localparam int DW = 10;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_empty_out, fifo_almost_full, fifo_almost_empty;
  logic          error_fifo_out, flush, ready_in;
  logic          fifo_read, valid_out, error_out, busy;
  logic [DW-1:0] data_out;
  logic [CW-1:0] word_count;

  // FIFO model (high_limit 6, low_limit 2) or direct flag override
  logic [DW-1:0] q_fifo [$];
  logic [DW-1:0] sb_q [$];
  logic [DW-1:0] m_rdata = '0;
  logic          m_empty = 1'b1, m_afull = 1'b0, m_aempty = 1'b1;
  logic          use_model;
  logic          v_empty, v_afull, v_aempty;
  int            reads_issued;
  int            delivered;
  int            checks = 0;
  int            errors = 0;

  assign fifo_empty_out    = use_model ? m_empty  : v_empty;
  assign fifo_almost_full  = use_model ? m_afull  : v_afull;
  assign fifo_almost_empty = use_model ? m_aempty : v_aempty;
  assign fifo_data_out     = m_rdata;

  always @(posedge clk) begin : p_model
    int sz;
    if (fifo_read) begin
      reads_issued++;
      if (q_fifo.size() > 0) m_rdata <= q_fifo.pop_front();
    end
    sz = q_fifo.size();
    m_empty  <= (sz == 0);
    m_afull  <= (sz >= 6);
    m_aempty <= (sz <= 2);
  end

  fifo_drain #(.DATA_BITS(DW), .CNT_BITS(CW)) u_dut (
    .clk               (clk),
    .reset             (reset),
    .fifo_data_out     (fifo_data_out),
    .fifo_empty_out    (fifo_empty_out),
    .fifo_almost_full  (fifo_almost_full),
    .fifo_almost_empty (fifo_almost_empty),
    .error_fifo_out    (error_fifo_out),
    .flush             (flush),
    .fifo_read         (fifo_read),
    .data_out          (data_out),
    .valid_out         (valid_out),
    .ready_in          (ready_in),
    .word_count        (word_count),
    .error_out         (error_out),
    .busy              (busy)
  );

  // Narrow-counter instance streaming continuously, used for the wrap check
  logic          w2_reset;
  logic [DW-1:0] w2_data = 10'h155;
  logic          w2_read, w2_valid, w2_err, w2_busy;
  logic [DW-1:0] w2_dout;
  logic [2:0]    w2_count;

  fifo_drain #(.DATA_BITS(DW), .CNT_BITS(3)) u_wrap (
    .clk               (clk),
    .reset             (w2_reset),
    .fifo_data_out     (w2_data),
    .fifo_empty_out    (1'b0),
    .fifo_almost_full  (1'b0),
    .fifo_almost_empty (1'b0),
    .error_fifo_out    (1'b0),
    .flush             (1'b1),
    .fifo_read         (w2_read),
    .data_out          (w2_dout),
    .valid_out         (w2_valid),
    .ready_in          (1'b1),
    .word_count        (w2_count),
    .error_out         (w2_err),
    .busy              (w2_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every delivered word must be the oldest expected one
  logic [DW-1:0] mon_exp;
  always @(negedge clk) begin
    if (!reset && valid_out && ready_in) begin
      delivered++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual=%0h expected=none", data_out);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("sb_data", 32'(data_out), 32'(mon_exp));
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; ready_in = 1'b0; flush = 1'b0; error_fifo_out = 1'b0;
    q_fifo.delete();
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    reads_issued = 0;
    delivered = 0;
    @(posedge clk); #1;
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      q_fifo.push_back(DW'(base + i));
      sb_q.push_back(DW'(base + i));
    end
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    chk({name, "_start_timeout"}, 32'(n < 20), 32'd1);
  endtask

  task automatic wait_quiet(input string name, input int lim);
    int n = 0;
    @(negedge clk);
    while ((busy || valid_out) && n < lim) begin @(negedge clk); n++; end
    chk({name, "_done_timeout"}, 32'(n < lim), 32'd1);
  endtask

  typedef struct {
    logic empty, afull, aempty, fl, err;
    logic exp_busy, exp_read, exp_err;
  } vec_t;

  vec_t vecs [7];
  logic [CW-1:0] frozen;
  int n;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; w2_reset = 1'b1; use_model = 1'b0;
    v_empty = 1'b1; v_afull = 1'b0; v_aempty = 1'b1;
    flush = 1'b0; ready_in = 1'b0; error_fifo_out = 1'b0;
    reads_issued = 0; delivered = 0;
    #1;
    chk("rst_read",  32'(fifo_read),  32'd0);
    chk("rst_valid", 32'(valid_out),  32'd0);
    chk("rst_data",  32'(data_out),   32'd0);
    chk("rst_count", 32'(word_count), 32'd0);
    chk("rst_err",   32'(error_out),  32'd0);
    chk("rst_busy",  32'(busy),       32'd0);

    // Single-step transitions out of IDLE with directly driven flags
    for (int i = 0; i < 7; i++) begin
      do_reset();
      v_empty = vecs[i].empty; v_afull = vecs[i].afull; v_aempty = vecs[i].aempty;
      flush = vecs[i].fl; error_fifo_out = vecs[i].err;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_busy", i), 32'(busy),      32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_read", i), 32'(fifo_read), 32'(vecs[i].exp_read));
      chk($sformatf("vec%0d_err", i),  32'(error_out), 32'(vecs[i].exp_err));
    end
    use_model = 1'b1;

    // Fill 5: below high watermark, nothing happens
    do_reset();
    fill(5, 'h100);
    repeat (10) @(negedge clk);
    chk("fill5_reads", 32'(reads_issued), 32'd0);
    chk("fill5_busy",  32'(busy),         32'd0);

    // Fill 6 with ready: drain down to low watermark
    do_reset();
    fill(6, 'h200);
    ready_in = 1'b1;
    wait_busy("fill6");
    wait_quiet("fill6", 50);
    chk("fill6_reads",     32'(reads_issued), 32'd4);
    chk("fill6_delivered", 32'(delivered),    32'd4);
    chk("fill6_count",     32'(word_count),   32'd4);
    chk("fill6_left",      32'(sb_q.size()),  32'd2);

    // Downstream stall during DRAIN
    do_reset();
    fill(6, 'h300);
    wait_busy("stall");
    repeat (8) @(negedge clk);
    chk("stall_reads", 32'(reads_issued), 32'd2);
    chk("stall_valid", 32'(valid_out),    32'd1);
    chk("stall_fread", 32'(fifo_read),    32'd0);
    chk("stall_data",  32'(data_out),     32'h300);
    @(posedge clk); #1;
    ready_in = 1'b1;
    wait_quiet("stall", 50);
    chk("stall_delivered", 32'(delivered),  32'd4);
    chk("stall_count",     32'(word_count), 32'd4);

    // Flush of a lightly filled FIFO
    do_reset();
    fill(3, 'h3A0);
    flush = 1'b1; ready_in = 1'b1;
    wait_busy("flush");
    wait_quiet("flush", 50);
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("flush_delivered", 32'(delivered),      32'd3);
    chk("flush_count",     32'(word_count),     32'd3);
    chk("flush_empty",     32'(fifo_empty_out), 32'd1);
    chk("flush_busy",      32'(busy),           32'd0);

    // Error pulse mid-burst
    do_reset();
    fill(6, 'h0E0);
    ready_in = 1'b1;
    n = 0;
    while (word_count != CW'(2) && n < 30) begin @(negedge clk); n++; end
    chk("err_start_timeout", 32'(n < 30), 32'd1);
    @(posedge clk); #1;
    error_fifo_out = 1'b1;
    @(posedge clk); #1;
    error_fifo_out = 1'b0;
    @(negedge clk);
    chk("err_flag",  32'(error_out), 32'd1);
    chk("err_valid", 32'(valid_out), 32'd0);
    chk("err_read",  32'(fifo_read), 32'd0);
    chk("err_busy",  32'(busy),      32'd0);
    frozen = word_count;
    repeat (5) @(negedge clk);
    chk("err_sticky", 32'(error_out),  32'd1);
    chk("err_frozen", 32'(word_count), 32'(frozen));
    chk("err_count",  32'(word_count), 32'(delivered));

    // 65535 transfers, stall with two buffered, then reset mid-burst
    do_reset();
    fill(65540, 0);
    flush = 1'b1; ready_in = 1'b1;
    n = 0;
    while (word_count != 16'hFFFF && n < 70000) begin @(posedge clk); #1; n++; end
    ready_in = 1'b0;
    chk("big_timeout", 32'(n < 70000), 32'd1);
    repeat (4) @(negedge clk);
    chk("big_count", 32'(word_count), 32'hFFFF);
    chk("big_valid", 32'(valid_out),  32'd1);
    chk("big_fread", 32'(fifo_read),  32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_read",  32'(fifo_read),  32'd0);
    chk("mid_rst_valid", 32'(valid_out),  32'd0);
    chk("mid_rst_data",  32'(data_out),   32'd0);
    chk("mid_rst_count", 32'(word_count), 32'd0);
    chk("mid_rst_err",   32'(error_out),  32'd0);
    chk("mid_rst_busy",  32'(busy),       32'd0);
    q_fifo.delete();
    sb_q.delete();
    flush = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    ready_in = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_count", 32'(word_count), 32'd0);
    chk("post_rst_valid", 32'(valid_out),  32'd0);

    // Counter wrap on the 3-bit instance
    @(posedge clk); #1;
    w2_reset = 1'b0;
    n = 0;
    while (w2_count != 3'd7 && n < 30) begin @(negedge clk); n++; end
    chk("wrap_timeout", 32'(n < 30), 32'd1);
    @(negedge clk);
    chk("wrap_zero", 32'(w2_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
